// File: rtl/align_accumulate_pkg.sv
// Shared SD4 MAC constants, accumulator state encoding and saturation limits.
package sd4_mac_pkg;

    localparam int NUM_LANES = 9;
    localparam int PP_W      = 5;
    localparam int EXP_W     = 5;
    localparam int GRP_W     = 13;

    typedef enum logic {
        EMPTY,
        ACCUM
    } acc_state_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/align_accumulate_if.sv
// Group input bundle and windowed result bundle of align_accumulate.
interface align_accumulate_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) ();
    import sd4_mac_pkg::*;

    logic                             in_valid;
    logic [NUM_LANES*PP_W-1:0]        pp_in;
    logic [NUM_LANES*EXP_W-1:0]       exp_in;
    logic [EXP_W-1:0]                 exp_max;
    logic [EXP_W-1:0]                 exp_bias;
    logic [LEN_W-1:0]                 acc_len;
    logic                             flush;

    logic                             out_valid;
    logic [ACC_W-1:0]                 acc_out;
    logic [EXP_W-1:0]                 out_exp;
    logic [EXP_W-1:0]                 out_bias;
    logic                             ovf;

    modport master (
        output in_valid, pp_in, exp_in, exp_max, exp_bias, acc_len, flush,
        input  out_valid, acc_out, out_exp, out_bias, ovf
    );

    modport slave (
        input  in_valid, pp_in, exp_in, exp_max, exp_bias, acc_len, flush,
        output out_valid, acc_out, out_exp, out_bias, ovf
    );

endinterface

// File: rtl/align_accumulate_pp_align.sv
// One lane: sign-extend, append guard bits, floor-shift to the group exponent.
module pp_align
    import sd4_mac_pkg::*;
#(
    parameter int G = 4
) (
    input  logic signed [PP_W-1:0]   pp,
    input  logic        [EXP_W-1:0]  shamt,
    output logic signed [PP_W+G-1:0] aligned
);

    logic signed [PP_W+G-1:0] ext;

    always_comb begin
        ext = {pp, {G{1'b0}}};
        if (shamt >= EXP_W'(PP_W + G)) begin
            aligned = {(PP_W + G){pp[PP_W-1]}};
        end else begin
            aligned = ext >>> shamt;
        end
    end

endmodule

// File: rtl/align_accumulate.sv
// Aligns nine partial products per group, sums them, and accumulates groups
// into a block-floating-point window emitted once per acc_len groups.
module align_accumulate
    import sd4_mac_pkg::*;
#(
    parameter int G     = 4,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    align_accumulate_if.slave bus
);

    localparam int AL_W = PP_W + G;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    logic signed [AL_W-1:0]  lane_al [NUM_LANES];
    logic signed [GRP_W-1:0] sum_c;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            pp_align #(.G(G)) u_align (
                .pp      (bus.pp_in[(NUM_LANES-1-i)*PP_W +: PP_W]),
                .shamt   (bus.exp_max - bus.exp_in[(NUM_LANES-1-i)*EXP_W +: EXP_W]),
                .aligned (lane_al[i])
            );
        end
    endgenerate

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            sum_c = sum_c + GRP_W'(lane_al[k]);
        end
    end

    logic                    grp_valid;
    logic signed [GRP_W-1:0] grp_sum;
    logic [EXP_W-1:0]        grp_exp;
    logic [EXP_W-1:0]        grp_bias;
    logic [LEN_W-1:0]        grp_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_valid <= 1'b0;
            grp_sum   <= '0;
            grp_exp   <= '0;
            grp_bias  <= '0;
            grp_len   <= '0;
        end else begin
            grp_valid <= bus.in_valid;
            if (bus.in_valid) begin
                grp_sum  <= sum_c;
                grp_exp  <= bus.exp_max;
                grp_bias <= bus.exp_bias;
                grp_len  <= bus.acc_len;
            end
        end
    end

    acc_state_t              state;
    logic signed [ACC_W-1:0] acc;
    logic [EXP_W-1:0]        acc_e;
    logic [LEN_W-1:0]        cnt;
    logic [LEN_W-1:0]        len;
    logic [EXP_W-1:0]        bias_q;
    logic                    sat;
    logic                    emit;

    logic signed [ACC_W-1:0] grp_ext;
    logic                    grow;
    logic [EXP_W-1:0]        diff;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [ACC_W-1:0] grp_sh;
    logic signed [ACC_W:0]   sum_w;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [LEN_W-1:0]        len_eff;

    // The operand with the smaller exponent is the one that loses precision.
    always_comb begin
        grp_ext = ACC_W'(grp_sum);
        grow    = grp_exp > acc_e;
        diff    = grow ? (grp_exp - acc_e) : (acc_e - grp_exp);
        acc_sh  = grow ? (acc >>> diff) : acc;
        grp_sh  = grow ? grp_ext : (grp_ext >>> diff);
        sum_w   = {acc_sh[ACC_W-1], acc_sh} + {grp_sh[ACC_W-1], grp_sh};
        add_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        acc_nxt = sum_w[ACC_W-1:0];
        if (add_ovf) begin
            acc_nxt = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        len_eff = (grp_len == '0) ? LEN_W'(1) : grp_len;
    end

    logic                    out_valid_q;
    logic [ACC_W-1:0]        acc_out_q;
    logic [EXP_W-1:0]        out_exp_q;
    logic [EXP_W-1:0]        out_bias_q;
    logic                    ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            acc         <= '0;
            acc_e       <= '0;
            cnt         <= '0;
            len         <= '0;
            bias_q      <= '0;
            sat         <= 1'b0;
            emit        <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            out_exp_q   <= '0;
            out_bias_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            emit <= 1'b0;
            unique case (state)
                EMPTY: begin
                    if (grp_valid) begin
                        acc    <= grp_ext;
                        acc_e  <= grp_exp;
                        cnt    <= LEN_W'(1);
                        len    <= len_eff;
                        bias_q <= grp_bias;
                        sat    <= 1'b0;
                        if (len_eff == LEN_W'(1) || bus.flush) begin
                            emit <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (grp_valid) begin
                        acc <= acc_nxt;
                        cnt <= cnt + LEN_W'(1);
                        if (grow) begin
                            acc_e <= grp_exp;
                        end
                        if (add_ovf) begin
                            sat <= 1'b1;
                        end
                    end
                    if ((grp_valid && (cnt + LEN_W'(1) == len)) || bus.flush) begin
                        emit  <= 1'b1;
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            // Window state is already final here, so it is copied verbatim.
            out_valid_q <= emit;
            if (emit) begin
                acc_out_q  <= acc;
                out_exp_q  <= acc_e;
                out_bias_q <= bias_q;
                ovf_q      <= sat;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_bias  = out_bias_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_align_accumulate.sv
// Randomized and directed bench for align_accumulate against a window-level
// arithmetic reference model.
module tb_align_accumulate;
    import sd4_mac_pkg::*;

    localparam int G     = 4;
    localparam int ACC_W = 14;
    localparam int LEN_W = 8;
    localparam longint LIM_MAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint LIM_MIN = -(longint'(1) << (ACC_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    align_accumulate_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    align_accumulate #(.G(G), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;

    int gpp [NUM_LANES];
    int gex [NUM_LANES];

    // Reference model state: one open window plus the group in Stage A.
    bit     m_open = 0;
    longint m_acc = 0;
    int     m_e = 0, m_cnt = 0, m_len = 0, m_bias = 0;
    bit     m_sat = 0;
    bit     pv = 0;
    longint pg = 0;
    int     pe = 0, plen = 0, pbias = 0;
    bit     pend_v = 0;
    longint pend_acc = 0;
    int     pend_e = 0, pend_b = 0;
    bit     pend_o = 0;
    bit     vis_v = 0;
    longint vis_acc = 0;
    int     vis_e = 0, vis_b = 0;
    bit     vis_o = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint clamp(input longint s, inout bit hit);
        if (s > LIM_MAX) begin
            hit = 1;
            return LIM_MAX;
        end
        if (s < LIM_MIN) begin
            hit = 1;
            return LIM_MIN;
        end
        return s;
    endfunction

    task automatic cycle(input bit v, input int bias, input int len,
                         input bit fl, input bit r);
        int     emax;
        longint g;
        longint a;
        bit     e_v;
        emax = 0;
        g = 0;
        for (int i = 0; i < NUM_LANES; i++)
            if (gex[i] > emax) emax = gex[i];
        for (int i = 0; i < NUM_LANES; i++)
            g += floor_div(longint'(gpp[i]) * (longint'(1) << G),
                           longint'(1) << (emax - gex[i]));
        bus.in_valid = v;
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.pp_in[(NUM_LANES-1-i)*PP_W +: PP_W]   = PP_W'(gpp[i]);
            bus.exp_in[(NUM_LANES-1-i)*EXP_W +: EXP_W] = EXP_W'(gex[i]);
        end
        bus.exp_max  = EXP_W'(emax);
        bus.exp_bias = EXP_W'(bias);
        bus.acc_len  = LEN_W'(len);
        bus.flush    = fl;
        rst          = r;
        if (r) begin
            m_open = 0;
            pv = 0;
            pend_v = 0;
            vis_v = 0;
            vis_acc = 0;
            vis_e = 0;
            vis_b = 0;
            vis_o = 0;
        end else begin
            vis_v = pend_v;
            if (pend_v) begin
                vis_acc = pend_acc;
                vis_e = pend_e;
                vis_b = pend_b;
                vis_o = pend_o;
            end
            e_v = 0;
            if (pv) begin
                if (!m_open) begin
                    m_open = 1;
                    m_acc = pg;
                    m_e = pe;
                    m_cnt = 1;
                    m_len = (plen == 0) ? 1 : plen;
                    m_bias = pbias;
                    m_sat = 0;
                    if (m_len == 1) e_v = 1;
                end else begin
                    if (pe > m_e) begin
                        m_acc = floor_div(m_acc, longint'(1) << (pe - m_e));
                        m_e = pe;
                        a = pg;
                    end else begin
                        a = floor_div(pg, longint'(1) << (m_e - pe));
                    end
                    m_acc = clamp(m_acc + a, m_sat);
                    m_cnt++;
                    if (m_cnt == m_len) e_v = 1;
                end
            end
            if (fl && m_open) e_v = 1;
            pend_v = e_v;
            if (e_v) begin
                pend_acc = m_acc;
                pend_e = m_e;
                pend_b = m_bias;
                pend_o = m_sat;
                m_open = 0;
            end
            pv = v;
            pg = g;
            pe = emax;
            plen = len;
            pbias = bias;
        end
        @(posedge clk);
        #1;
        chk("out_valid", longint'(bus.out_valid), longint'(vis_v));
        chk("acc_out", longint'($signed(bus.acc_out)), vis_acc);
        chk("out_exp", longint'(bus.out_exp), longint'(vis_e));
        chk("out_bias", longint'(bus.out_bias), longint'(vis_b));
        chk("ovf", longint'(bus.ovf), longint'(vis_o));
        if (bus.out_valid) n_pulse++;
    endtask

    task automatic fill(input int p, input int e);
        for (int i = 0; i < NUM_LANES; i++) begin
            gpp[i] = p;
            gex[i] = e;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.pp_in = '0;
        bus.exp_in = '0;
        bus.exp_max = '0;
        bus.exp_bias = '0;
        bus.acc_len = '0;
        bus.flush = 0;
        fill(0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1);

        fill(1, 3);
        cycle(1, 7, 1, 0, 0);
        idle(2);
        chk("tp_uniform_acc", longint'($signed(bus.acc_out)), 144);
        chk("tp_uniform_bias", longint'(bus.out_bias), 7);

        fill(0, 5);
        gpp[0] = -8;
        gpp[1] = 7;
        gex[1] = 3;
        cycle(1, 2, 1, 0, 0);
        idle(2);
        chk("tp_align_acc", longint'($signed(bus.acc_out)), -100);
        chk("tp_align_exp", longint'(bus.out_exp), 5);

        fill(1, 3);
        cycle(1, 4, 2, 0, 0);
        fill(0, 0);
        gpp[0] = 1;
        gex[0] = 5;
        cycle(1, 9, 2, 0, 0);
        idle(2);
        chk("tp_grow_acc", longint'($signed(bus.acc_out)), 52);
        chk("tp_grow_exp", longint'(bus.out_exp), 5);

        fill(-16, 0);
        for (int k = 0; k < 4; k++) cycle(1, 1, 4, 0, 0);
        idle(2);
        chk("tp_sat_acc", longint'($signed(bus.acc_out)), -8192);
        chk("tp_sat_ovf", longint'(bus.ovf), 1);
        fill(1, 0);
        cycle(1, 1, 1, 0, 0);
        idle(2);
        chk("tp_sat_next_ovf", longint'(bus.ovf), 0);

        n_pulse = 0;
        fill(2, 1);
        for (int k = 0; k < 6; k++) cycle(1, 3, 3, 0, 0);
        idle(3);
        chk("tp_b2b_pulses", n_pulse, 2);

        n_pulse = 0;
        fill(3, 2);
        cycle(1, 5, 5, 0, 0);
        cycle(1, 5, 5, 0, 0);
        cycle(0, 0, 0, 1, 0);
        idle(2);
        chk("tp_flush_pulses", n_pulse, 1);

        n_pulse = 0;
        cycle(1, 5, 5, 0, 0);
        cycle(1, 5, 5, 0, 0);
        cycle(0, 0, 0, 0, 1);
        idle(3);
        chk("tp_reset_pulses", n_pulse, 0);
        chk("tp_reset_acc", longint'($signed(bus.acc_out)), 0);

        for (int k = 0; k < 3000; k++) begin
            bit r, v, fl;
            int base;
            r = ($urandom_range(0, 249) == 0);
            v = !r && ($urandom_range(0, 9) < 7);
            fl = !r && ($urandom_range(0, 19) == 0);
            base = $urandom_range(0, 28);
            for (int i = 0; i < NUM_LANES; i++) begin
                gpp[i] = int'($urandom_range(0, 31)) - 16;
                if ($urandom_range(0, 3) == 0) gex[i] = $urandom_range(0, 31);
                else gex[i] = base + int'($urandom_range(0, 3));
            end
            cycle(v, $urandom_range(0, 31), $urandom_range(0, 6), fl, r);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/align_accumulate.md
# align_accumulate

Downstream neighbour of the partial-product/max-exponent stage in the SD4 MAC pipeline. Each cycle it accepts one group of nine registered signed partial products, their exponents, the group maximum exponent and the exponent bias. It aligns every product to the group maximum and sums them through a registered adder tree. It then accumulates successive groups into a block-floating-point accumulator and emits one result per window of `acc_len` groups.

## Interface
- `G`, 4: guard bits appended below the LSB before alignment.
- `ACC_W`, 24: accumulator width, two's complement; must be ≥ 13.
- `LEN_W`, 8: width of the window-length input.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: group present on the inputs this cycle.
- `pp_in` input 45: nine 5-bit two's-complement partial products; lane 0 at [44:40], lane 8 at [4:0].
- `exp_in` input 45: nine 5-bit unsigned exponents, same lane order.
- `exp_max` input 5: maximum of the nine `exp_in` values.
- `exp_bias` input 5: bias passed through to the output.
- `acc_len` input LEN_W: groups per window, sampled at window start; 0 is treated as 1.
- `flush` input 1: close the open window early.
- `out_valid` output 1: one-cycle result pulse.
- `acc_out` output ACC_W: accumulated mantissa; value = `acc_out`·2^(`out_exp`−G).
- `out_exp` output 5: accumulator exponent.
- `out_bias` output 5: `exp_bias` latched at window start.
- `ovf` output 1: saturation occurred within the emitted window.

## Operation
- **Stage A (align + sum), registered.**
  - Per lane: sign-extend `pp_in` to 5+G bits and shift left by G.
  - Arithmetic shift right by `exp_max`−`exp_in` (floor). A shift ≥ 9 yields pure sign fill.
  - Sum the nine lanes into 13-bit signed `grp_sum`.
  - Register `grp_sum`, `exp_max`, `exp_bias`, `acc_len` and `grp_valid`.
- **Stage B (accumulate), FSM `EMPTY` / `ACCUM`, counter `cnt` (LEN_W bits).**
  - In `EMPTY`, with `grp_valid`:
    - `acc` ← sign-extended `grp_sum`; `acc_e` ← group exponent; `cnt` ← 1.
    - Latch `len`, latch the bias, clear the sticky `sat`.
    - If `len` ≤ 1, emit and stay in `EMPTY`; otherwise go to `ACCUM`.
  - In `ACCUM`, with `grp_valid`:
    - If group exponent > `acc_e`: arithmetic-shift `acc` right by the difference, then `acc_e` ← group exponent.
    - Otherwise shift `grp_sum` right by `acc_e` − group exponent.
    - Add. On overflow, clamp to ±(2^(ACC_W−1)) limits (max 2^(ACC_W−1)−1, min −2^(ACC_W−1)) and set `sat`.
    - `cnt`++. When `cnt`+1 == `len`, emit and go to `EMPTY`.
  - Emit: register `acc_out`, `out_exp`, `out_bias`, `ovf` = `sat` (including this cycle's saturation). Pulse `out_valid` for exactly one cycle.
- **`flush`**, evaluated in Stage B:
  - `ACCUM` or `grp_valid` present: include any valid group, then emit a partial window and go to `EMPTY`.
  - `EMPTY` without `grp_valid`: no effect.
- No backpressure; a group is accepted every cycle `in_valid` is high.

## Timing
- Reset: all outputs 0, FSM `EMPTY`, `cnt` = 0, `grp_valid` = 0, `sat` = 0.
- Latency: a group sampled at edge t updates Stage B at edge t+1. A window closed by that group drives `out_valid` high in the cycle after edge t+2.
- Back-to-back windows have no bubble: a group arriving the cycle after an emit opens the next window.
- Outputs hold their last values between pulses.
- Reset mid-window: the partial window and the in-flight Stage A group are discarded, with no emission.
- `in_valid` low: the pipeline bubbles and state is held.

## Structure
- Shared package `sd4_mac_pkg`:
  - constants `NUM_LANES`=9, `PP_W`=5, `EXP_W`=5, `GRP_W`=13;
  - typedef `acc_state_t` {`EMPTY`, `ACCUM`};
  - saturation-limit functions.
- One sub-module, `pp_align`: a combinational per-lane sign-extend/guard/shift, instantiated nine times.

## Test plan
- **Uniform group, single window:** `acc_len`=1; all pp=1, all exp=3, `exp_max`=3, bias=7 → `out_valid` at t+2 with `acc_out`=144, `out_exp`=3, `out_bias`=7, `ovf`=0.
- **Alignment:** `exp_max`=5; lane0 pp=−8 exp 5; lane1 pp=7 exp 3; other lanes 0 → `acc_out`=−100, `out_exp`=5.
- **Exponent growth:** `acc_len`=2; group (sum 144, exp 3), then group (lane0 pp=1 exp 5, others 0) → `acc_out`=52, `out_exp`=5.
- **Saturation:** `ACC_W`=14, `acc_len`=4; four groups of all pp=−16, exp 0 → `acc_out`=−8192, `ovf`=1. The next window reports `ovf`=0.
- **Back-to-back:** `acc_len`=3, six consecutive valid groups → exactly two `out_valid` pulses, 3 cycles apart.
- **Flush and reset:**
  - Two groups with `acc_len`=5, then `flush` → partial result emitted.
  - Repeat with `rst` asserted instead of `flush` → no pulse, and all outputs read 0.
